// File: rtl/ram_burst_pkg.sv
// Shared types and constants for the RAM burst reader.
package ram_burst_pkg;

  localparam int unsigned CFifoDepth  = 4;
  localparam int unsigned CFifoPtrLen = $clog2(CFifoDepth);
  localparam logic [CFifoPtrLen:0] CFifoFull = (CFifoPtrLen + 1)'(CFifoDepth);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StDrain = 2'd2
  } burstStateT;

endpackage

// File: rtl/ram_burst_fifo.sv
// Small register-based FIFO holding RAM words plus their burst-last flag.
module ram_burst_fifo
  import ram_burst_pkg::*;
#(
  parameter int unsigned CWidth = 129
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   pushEn,
  input  logic [CWidth-1:0]      pushData,
  input  logic                   popEn,
  output logic [CWidth-1:0]      headData,
  output logic                   notEmpty,
  output logic [CFifoPtrLen:0]   occupancy
);

  logic [CWidth-1:0]      mem [CFifoDepth];
  logic [CFifoPtrLen-1:0] wrPtr;
  logic [CFifoPtrLen-1:0] rdPtr;
  logic [CFifoPtrLen:0]   count;
  logic                   doPush;
  logic                   doPop;

  assign doPush    = en && pushEn;
  assign doPop     = en && popEn && (count != '0);
  assign headData  = mem[rdPtr];
  assign notEmpty  = (count != '0);
  assign occupancy = count;

  // Storage, pointers and occupancy; push and pop together keep the count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem   <= '{default: '0};
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) begin
        mem[wrPtr] <= pushData;
        wrPtr      <= wrPtr + 1'b1;
      end
      if (doPop) begin
        rdPtr <= rdPtr + 1'b1;
      end
      unique case ({doPush, doPop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // The read-issue credit must make a push into a full FIFO impossible.
  assert property (@(posedge clk) disable iff (rst)
    !(doPush && !doPop && (count == CFifoFull)));

endmodule

// File: rtl/ram_burst_rd.sv
// Burst reader: turns (address, length) commands into single-port RAM reads
// and streams the returned words out through a valid/ready handshake.
module ram_burst_rd
  import ram_burst_pkg::*;
#(
  parameter int unsigned CAddrLen = 13,
  parameter int unsigned CDataLen = 128,
  parameter int unsigned CLenLen  = 8
) (
  input  logic                AClkH,
  input  logic                AResetH,
  input  logic                AClkHEn,
  input  logic [CAddrLen-1:0] ACmdAddr,
  input  logic [CLenLen-1:0]  ACmdLen,
  input  logic                ACmdVld,
  output logic                ACmdRdy,
  output logic [CAddrLen-1:0] ARamAddr,
  output logic                ARamRdEn,
  output logic                ARamWrEn,
  output logic [CDataLen-1:0] ARamMosi,
  input  logic [CDataLen-1:0] ARamMiso,
  output logic [CDataLen-1:0] AData,
  output logic                ADataVld,
  input  logic                ADataRdy,
  output logic                ADataLast,
  output logic                ABusy
);

  burstStateT           state;
  burstStateT           stateNxt;
  logic [CAddrLen-1:0]  nextAddr;
  logic [CLenLen-1:0]   remaining;
  logic                 rdLast;
  logic                 inFlight;
  logic                 inFlightLast;
  logic                 issue;
  logic                 cmdStart;
  logic                 credit;
  logic [CFifoPtrLen:0] occupancy;
  logic [CFifoPtrLen:0] pending;
  logic                 fifoNotEmpty;
  logic [CDataLen:0]    fifoHead;

  assign ARamWrEn = 1'b0;
  assign ARamMosi = '0;
  assign ACmdRdy  = (state == StIdle);
  assign ABusy    = (state != StIdle);
  assign cmdStart = (state == StIdle) && ACmdVld && (ACmdLen != '0);

  // Words owed to the FIFO: stored ones, the read on the RAM port and the
  // one whose data is arriving now.
  assign pending = occupancy + (CFifoPtrLen + 1)'(ARamRdEn) + (CFifoPtrLen + 1)'(inFlight);
  assign credit  = (pending < CFifoFull);

  // FSM state register.
  always_ff @(posedge AClkH or posedge AResetH) begin
    if (AResetH) begin
      state <= StIdle;
    end else if (AClkHEn) begin
      state <= stateNxt;
    end
  end

  // Next-state logic and read-issue decision.
  always_comb begin
    stateNxt = state;
    issue    = 1'b0;
    unique case (state)
      StIdle: begin
        if (cmdStart) begin
          stateNxt = StRun;
        end
      end
      StRun: begin
        if (credit) begin
          issue = 1'b1;
          if (remaining == CLenLen'(1)) begin
            stateNxt = StDrain;
          end
        end
      end
      StDrain: begin
        if (!fifoNotEmpty && !ARamRdEn && !inFlight) begin
          stateNxt = StIdle;
        end
      end
      default: stateNxt = StIdle;
    endcase
  end

  // Read address/strobe generation and the one-cycle in-flight pipeline.
  always_ff @(posedge AClkH or posedge AResetH) begin
    if (AResetH) begin
      ARamRdEn     <= 1'b0;
      ARamAddr     <= '0;
      rdLast       <= 1'b0;
      inFlight     <= 1'b0;
      inFlightLast <= 1'b0;
      nextAddr     <= '0;
      remaining    <= '0;
    end else if (AClkHEn) begin
      ARamRdEn     <= issue;
      rdLast       <= issue && (remaining == CLenLen'(1));
      inFlight     <= ARamRdEn;
      inFlightLast <= rdLast;
      if (issue) begin
        ARamAddr  <= nextAddr;
        nextAddr  <= nextAddr + 1'b1;
        remaining <= remaining - 1'b1;
      end
      if (cmdStart) begin
        nextAddr  <= ACmdAddr;
        remaining <= ACmdLen;
      end
    end
  end

  ram_burst_fifo #(
    .CWidth(CDataLen + 1)
  ) uFifo (
    .clk      (AClkH),
    .rst      (AResetH),
    .en       (AClkHEn),
    .pushEn   (inFlight),
    .pushData ({inFlightLast, ARamMiso}),
    .popEn    (ADataRdy),
    .headData (fifoHead),
    .notEmpty (fifoNotEmpty),
    .occupancy(occupancy)
  );

  // Stale FIFO slots are masked so data and last read as zero when empty.
  assign ADataVld  = fifoNotEmpty;
  assign AData     = fifoNotEmpty ? fifoHead[CDataLen-1:0] : '0;
  assign ADataLast = fifoNotEmpty && fifoHead[CDataLen];

endmodule

// File: tb/tb_ram_burst_rd.sv
// Self-checking bench for ram_burst_rd: table of bursts, hand-written corner
// sequences and random commands, all checked against a queue-based model.
module tb_ram_burst_rd;

  logic         clk;
  logic         AResetH;
  logic         AClkHEn;
  logic [12:0]  ACmdAddr;
  logic [7:0]   ACmdLen;
  logic         ACmdVld;
  logic         ACmdRdy;
  logic [12:0]  ARamAddr;
  logic         ARamRdEn;
  logic         ARamWrEn;
  logic [127:0] ARamMosi;
  logic [127:0] ARamMiso;
  logic [127:0] AData;
  logic         ADataVld;
  logic         ADataRdy;
  logic         ADataLast;
  logic         ABusy;

  ram_burst_rd #(
    .CAddrLen(13),
    .CDataLen(128),
    .CLenLen (8)
  ) dut (
    .AClkH    (clk),
    .AResetH  (AResetH),
    .AClkHEn  (AClkHEn),
    .ACmdAddr (ACmdAddr),
    .ACmdLen  (ACmdLen),
    .ACmdVld  (ACmdVld),
    .ACmdRdy  (ACmdRdy),
    .ARamAddr (ARamAddr),
    .ARamRdEn (ARamRdEn),
    .ARamWrEn (ARamWrEn),
    .ARamMosi (ARamMosi),
    .ARamMiso (ARamMiso),
    .AData    (AData),
    .ADataVld (ADataVld),
    .ADataRdy (ADataRdy),
    .ADataLast(ADataLast),
    .ABusy    (ABusy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nChecks = 0;
  int nPass   = 0;

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    nChecks++;
    if (act === exp) nPass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // RAM contents are a fixed function of the address.
  function automatic logic [127:0] ramWord(input logic [12:0] a);
    logic [31:0] x;
    x = {19'h0, a};
    return {x ^ 32'hA5A5_5A5A, x * 32'h9E37_79B1, ~x, x + 32'h0BAD_0000};
  endfunction

  // Synchronous single-port RAM model: data one enabled cycle after the strobe.
  always @(posedge clk) begin
    if (AClkHEn && ARamRdEn) ARamMiso <= ramWord(ARamAddr);
  end

  // Reference model state: expected read addresses and output words.
  logic [12:0]  expAddrQ[$];
  logic [128:0] expDataQ[$];
  int           readsSeen = 0;
  int           wordsSeen = 0;
  int           lastsSeen = 0;
  logic [12:0]  lastRdAddr = '0;
  logic         prevEn = 1'b1;
  logic [159:0] prevSnap = '0;
  logic [159:0] snap;

  // Monitor, sampled on the falling edge: transfers happen at the next rising edge.
  always @(negedge clk) begin
    if (AResetH) begin
      expAddrQ.delete();
      expDataQ.delete();
      prevEn = 1'b1;
    end else begin
      snap = {ACmdRdy, ARamRdEn, ARamAddr, ADataVld, ADataLast, ABusy, AData};
      if (!prevEn) chk("holdWhenDisabled", snap, prevSnap);
      prevSnap = snap;
      prevEn   = AClkHEn;
      if (AClkHEn && ACmdVld && ACmdRdy) begin
        for (int i = 0; i < int'(ACmdLen); i++) begin
          logic [12:0] a;
          a = 13'(ACmdAddr + 13'(i));
          expAddrQ.push_back(a);
          expDataQ.push_back({(i == int'(ACmdLen) - 1), ramWord(a)});
        end
      end
      if (AClkHEn && ARamRdEn) begin
        chk("readExpected", (expAddrQ.size() != 0), 1);
        if (expAddrQ.size() != 0) chk("readAddr", ARamAddr, expAddrQ.pop_front());
        readsSeen++;
        lastRdAddr = ARamAddr;
      end
      if (AClkHEn && ADataVld && ADataRdy) begin
        chk("wordExpected", (expDataQ.size() != 0), 1);
        if (expDataQ.size() != 0) chk("wordData", {ADataLast, AData}, expDataQ.pop_front());
        wordsSeen++;
        if (ADataLast) lastsSeen++;
      end
    end
  end

  int   enMode  = 0;   // 0 always on, 1 alternating, 2 random
  int   rdyMode = 0;   // 0 always ready, 1 never ready, 2 random
  logic altPh   = 1'b0;

  task automatic tick();
    @(posedge clk);
    #1;
    case (enMode)
      0: AClkHEn = 1'b1;
      1: begin altPh = !altPh; AClkHEn = altPh; end
      default: AClkHEn = ($urandom_range(0, 3) != 0);
    endcase
    case (rdyMode)
      0: ADataRdy = 1'b1;
      1: ADataRdy = 1'b0;
      default: ADataRdy = 1'($urandom_range(0, 1));
    endcase
  endtask

  task automatic sendCmd(input logic [12:0] a, input logic [7:0] l, output int waited);
    logic acc;
    ACmdAddr = a;
    ACmdLen  = l;
    ACmdVld  = 1'b1;
    waited   = 0;
    acc      = 1'b0;
    while (!acc && waited < 100) begin
      acc = AClkHEn && ACmdRdy;
      tick();
      waited++;
    end
    ACmdVld = 1'b0;
    chk("cmdAccepted", acc, 1);
  endtask

  task automatic waitIdle();
    int n;
    n = 0;
    while (!(!ABusy && !ADataVld && expDataQ.size() == 0) && n < 2000) begin
      tick();
      n++;
    end
    chk("idleTimeout", (n < 2000), 1);
  endtask

  typedef struct {
    logic [12:0] addr;
    logic [7:0]  len;
    int          enMode;
    int          rdyMode;
    int          expWords;
    logic [12:0] expLastAddr;
  } vecT;

  vecT tbl[8];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, r0, w0, l0, cnt, n, v;
    logic [12:0] a;
    logic        rdT[16];
    logic [12:0] adT[16];
    logic        vlT[16];
    logic        lsT[16];

    tbl[0] = '{13'h0010,   8'd4, 0, 0,   4, 13'h0013};
    tbl[1] = '{13'h1FFE,   8'd4, 0, 0,   4, 13'h0001};
    tbl[2] = '{13'h1FFF,   8'd1, 0, 0,   1, 13'h1FFF};
    tbl[3] = '{13'h0100,   8'd8, 0, 2,   8, 13'h0107};
    tbl[4] = '{13'h0AAA,  8'd20, 1, 0,  20, 13'h0ABD};
    tbl[5] = '{13'h1FF8,  8'd16, 2, 2,  16, 13'h0007};
    tbl[6] = '{13'h0555, 8'd255, 0, 0, 255, 13'h0653};
    tbl[7] = '{13'h0010,   8'd4, 1, 0,   4, 13'h0013};

    AResetH  = 1'b1;
    AClkHEn  = 1'b1;
    ADataRdy = 1'b1;
    ACmdVld  = 1'b0;
    ACmdAddr = '0;
    ACmdLen  = '0;
    tick();
    tick();
    chk("rstOutputsZero", {ARamRdEn, ARamAddr, ADataVld, ADataLast, ABusy, AData}, 0);
    chk("rstWrZero", {ARamWrEn, ARamMosi}, 0);
    AResetH = 1'b0;
    tick();
    chk("rstCmdRdy", ACmdRdy, 1);

    // Exact timing of a 4-word burst with the sink always ready.
    sendCmd(13'h0010, 8'd4, w);
    for (int t = 0; t < 16; t++) begin
      rdT[t] = ARamRdEn; adT[t] = ARamAddr; vlT[t] = ADataVld; lsT[t] = ADataLast;
      tick();
    end
    n = 0;
    for (int t = 15; t >= 0; t--) if (rdT[t]) n = t;
    if (n > 10) n = 10;
    for (int k = 0; k < 4; k++) begin
      chk("seqRdEn", rdT[n + k], 1);
      chk("seqAddr", adT[n + k], 13'h0010 + 13'(k));
    end
    chk("seqRdEnOff", rdT[n + 4], 0);
    chk("seqNoEarlyVld", vlT[n + 1], 0);
    v = 15;
    for (int t = 15; t > n + 1; t--) if (vlT[t]) v = t;
    if (v > 11) v = 11;
    for (int k = 0; k < 4; k++) chk("seqVldBackToBack", vlT[v + k], 1);
    chk("seqLastOn4th", {lsT[v + 2], lsT[v + 3]}, 2'b01);
    chk("seqVldOff", vlT[v + 4], 0);
    waitIdle();

    // Sink stalled: only as many reads as the FIFO can absorb.
    r0 = readsSeen; w0 = wordsSeen; l0 = lastsSeen;
    rdyMode = 1;
    tick();
    sendCmd(13'h0200, 8'd8, w);
    cnt = 0;
    for (int t = 0; t < 12; t++) begin
      if (ARamRdEn) cnt++;
      tick();
    end
    chk("stallReads", cnt, 4);
    chk("stallRdEnLow", ARamRdEn, 0);
    chk("stallVld", ADataVld, 1);
    rdyMode = 0;
    tick();
    waitIdle();
    chk("stallWords", wordsSeen - w0, 8);
    chk("stallReadsTotal", readsSeen - r0, 8);
    chk("stallLasts", lastsSeen - l0, 1);

    // Null command: consumed in one cycle, nothing else happens.
    r0 = readsSeen; w0 = wordsSeen;
    sendCmd(13'h0123, 8'd0, w);
    chk("nullAcceptCycles", w, 1);
    for (int t = 0; t < 5; t++) begin
      chk("nullQuiet", {ARamRdEn, ADataVld, ABusy, ACmdRdy}, 4'b0001);
      tick();
    end
    chk("nullNoTraffic", (readsSeen - r0) + (wordsSeen - w0), 0);

    // Table of bursts under various enable/ready patterns.
    for (int i = 0; i < 8; i++) begin
      enMode  = tbl[i].enMode;
      rdyMode = tbl[i].rdyMode;
      tick();
      r0 = readsSeen; w0 = wordsSeen; l0 = lastsSeen;
      sendCmd(tbl[i].addr, tbl[i].len, w);
      waitIdle();
      chk("tblReads", readsSeen - r0, tbl[i].expWords);
      chk("tblWords", wordsSeen - w0, tbl[i].expWords);
      chk("tblLasts", lastsSeen - l0, 1);
      chk("tblLastAddr", lastRdAddr, tbl[i].expLastAddr);
    end
    enMode = 0;
    rdyMode = 0;
    tick();

    // Reset in the middle of a 6-word burst.
    w0 = wordsSeen;
    sendCmd(13'h0300, 8'd6, w);
    n = 0;
    while ((wordsSeen - w0) < 2 && n < 50) begin
      tick();
      n++;
    end
    chk("midRstReached", (wordsSeen - w0), 2);
    AResetH = 1'b1;
    #1;
    chk("midRstZero", {ARamRdEn, ARamAddr, ADataVld, ADataLast, ABusy, AData}, 0);
    tick();
    tick();
    AResetH = 1'b0;
    tick();
    chk("midRstCmdRdy", ACmdRdy, 1);
    cnt = 0;
    for (int t = 0; t < 20; t++) begin
      if (ADataVld || ARamRdEn || ABusy) cnt++;
      tick();
    end
    chk("midRstNoMore", cnt, 0);

    // Random commands, enables and back-pressure.
    for (int i = 0; i < 40; i++) begin
      enMode  = ($urandom_range(0, 1) != 0) ? 2 : 0;
      rdyMode = ($urandom_range(0, 1) != 0) ? 2 : 0;
      tick();
      a = 13'($urandom);
      if ($urandom_range(0, 3) == 0) a = 13'h1FF0 | 13'($urandom_range(0, 15));
      r0 = readsSeen; w0 = wordsSeen; l0 = lastsSeen;
      cnt = $urandom_range(0, 12);
      sendCmd(a, 8'(cnt), w);
      waitIdle();
      chk("rndWords", wordsSeen - w0, cnt);
      chk("rndLasts", lastsSeen - l0, (cnt != 0) ? 1 : 0);
    end
    enMode = 0;
    rdyMode = 0;
    tick();
    chk("modelDrained", expAddrQ.size() + expDataQ.size(), 0);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
